// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encodings and the byte and gap-counter widths.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;
  localparam int GAP_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_GAP        = 3'd5,
    ST_HOLD       = 3'd6
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner select, combinational. The search starts one past last_idx,
// so the previous owner has the lowest priority. Zero latency, no backpressure.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_idx) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found            = 1'b1;
        win_onehot[cand] = 1'b1;
        win_idx          = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte streams; holds a grant for a whole message.
// DV one cycle after a valid is seen in IDLE; requesters stall until their Ready pulse.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = 2,
  parameter int GAP_CLKS = 0
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic [NUM_REQ-1:0]        i_Req_Valid,
  input  logic [BYTE_W*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]        i_Req_Last,
  output logic [NUM_REQ-1:0]        o_Req_Ready,
  output logic                      o_Tx_DV,
  output logic [BYTE_W-1:0]         o_Tx_Byte,
  input  logic                      i_Tx_Active,
  input  logic                      i_Tx_Done,
  output logic [NUM_REQ-1:0]        o_Grant,
  output logic [IDX_W-1:0]          o_Owner_Idx,
  output logic                      o_Busy
);

  localparam logic [IDX_W-1:0] OWNER_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CLKS - 1);

  arb_state_t          state_r, state_nxt;
  logic [NUM_REQ-1:0]  grant_nxt, ready_nxt, pick_onehot;
  logic [IDX_W-1:0]    owner_nxt, pick_idx;
  logic                pick_any, tx_free, post_byte, dv_nxt;
  logic                last_r, last_nxt;
  logic [GAP_W-1:0]    gap_cnt_r, gap_cnt_nxt;
  logic [BYTE_W-1:0]   byte_nxt;
  logic [BYTE_W-1:0]   req_byte [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req_byte
    assign req_byte[k] = i_Req_Byte[k*BYTE_W +: BYTE_W];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (i_Req_Valid),
    .last_idx   (o_Owner_Idx),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any_req    (pick_any)
  );

  // uart_tx has no reset, so "free" also covers a byte left running across our reset.
  assign tx_free = !i_Tx_Active && !i_Tx_Done;
  assign o_Busy  = (state_r != ST_IDLE);

  always_comb begin
    state_nxt   = state_r;
    grant_nxt   = o_Grant;
    owner_nxt   = o_Owner_Idx;
    last_nxt    = last_r;
    gap_cnt_nxt = gap_cnt_r;
    post_byte   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (tx_free && pick_any) begin
          grant_nxt = pick_onehot;
          owner_nxt = pick_idx;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        last_nxt  = i_Req_Last[o_Owner_Idx];
        state_nxt = ST_WAIT_START;
      end
      ST_WAIT_START: if (i_Tx_Active) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE:  if (i_Tx_Done)   state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        // Done stays high for two cycles; waiting for it to drop prevents a double DV.
        if (tx_free) begin
          if (GAP_CLKS > 0) begin
            state_nxt   = ST_GAP;
            gap_cnt_nxt = '0;
          end else begin
            post_byte = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) post_byte = 1'b1;
        else                       gap_cnt_nxt = gap_cnt_r + GAP_W'(1);
      end
      ST_HOLD: if (i_Req_Valid[o_Owner_Idx]) state_nxt = ST_LOAD;
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase

    if (post_byte) begin
      if (last_r) begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end else if (i_Req_Valid[o_Owner_Idx]) begin
        state_nxt = ST_LOAD;
      end else begin
        state_nxt = ST_HOLD;
      end
    end

    // Outputs are registered so that they are high exactly during the LOAD cycle.
    dv_nxt    = (state_nxt == ST_LOAD);
    ready_nxt = dv_nxt ? grant_nxt : '0;
    byte_nxt  = dv_nxt ? req_byte[owner_nxt] : o_Tx_Byte;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_r     <= ST_IDLE;
      o_Grant     <= '0;
      o_Owner_Idx <= OWNER_RST;
      last_r      <= 1'b0;
      gap_cnt_r   <= '0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= '0;
      o_Req_Ready <= '0;
    end else begin
      state_r     <= state_nxt;
      o_Grant     <= grant_nxt;
      o_Owner_Idx <= owner_nxt;
      last_r      <= last_nxt;
      gap_cnt_r   <= gap_cnt_nxt;
      o_Tx_DV     <= dv_nxt;
      o_Tx_Byte   <= byte_nxt;
      o_Req_Ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: DUT A (no gap) drives a uart_tx model at 4 clocks per bit;
// DUT B (GAP_CLKS=7) has its transmitter handshake driven directly by the stimulus.
module tb_uart_tx_arbiter;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dv_cnt = 0;
  int rdy_cnt = 0;

  logic [9:0] dv_q[$];   // {owner, byte} expected on each A DV
  logic [7:0] ser_q[$];  // bytes expected on the A serial line

  // ---------------- DUT A ----------------
  logic        rv[4];
  logic [7:0]  rb[4];
  logic        rl[4];
  logic [3:0]  a_valid, a_last, a_ready, a_grant;
  logic [31:0] a_byte;
  logic        a_dv, a_busy;
  logic [7:0]  a_tx_byte;
  logic [1:0]  a_owner;
  logic        a_tx_active = 1'b0;
  logic        a_tx_done = 1'b0;
  logic        a_ser = 1'b1;

  always_comb begin
    a_valid = '0;
    a_last  = '0;
    a_byte  = '0;
    for (int k = 0; k < 4; k++) begin
      a_valid[k]       = rv[k];
      a_last[k]        = rl[k];
      a_byte[8*k +: 8] = rb[k];
    end
  end

  uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .GAP_CLKS(0)) dut_a (
    .i_Clock(clk), .i_Reset(rst),
    .i_Req_Valid(a_valid), .i_Req_Byte(a_byte), .i_Req_Last(a_last),
    .o_Req_Ready(a_ready), .o_Tx_DV(a_dv), .o_Tx_Byte(a_tx_byte),
    .i_Tx_Active(a_tx_active), .i_Tx_Done(a_tx_done),
    .o_Grant(a_grant), .o_Owner_Idx(a_owner), .o_Busy(a_busy)
  );

  // uart_tx behaviour: no reset, Done high for two cycles after the stop bit
  logic [2:0] m_st = 3'd0;
  int         m_cnt = 0;
  logic [2:0] m_bit = 3'd0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk) begin
    case (m_st)
      3'd0: begin
        a_ser <= 1'b1; a_tx_done <= 1'b0; m_cnt <= 0; m_bit <= 3'd0;
        if (a_dv) begin a_tx_active <= 1'b1; m_data <= a_tx_byte; m_st <= 3'd1; end
      end
      3'd1: begin
        a_ser <= 1'b0;
        if (m_cnt < CPB-1) m_cnt <= m_cnt + 1;
        else begin m_cnt <= 0; m_st <= 3'd2; end
      end
      3'd2: begin
        a_ser <= m_data[m_bit];
        if (m_cnt < CPB-1) m_cnt <= m_cnt + 1;
        else begin
          m_cnt <= 0;
          if (m_bit != 3'd7) m_bit <= m_bit + 3'd1;
          else begin m_bit <= 3'd0; m_st <= 3'd3; end
        end
      end
      3'd3: begin
        a_ser <= 1'b1;
        if (m_cnt < CPB-1) m_cnt <= m_cnt + 1;
        else begin m_cnt <= 0; a_tx_done <= 1'b1; a_tx_active <= 1'b0; m_st <= 3'd4; end
      end
      default: begin a_tx_done <= 1'b1; m_st <= 3'd0; end
    endcase
  end

  // ---------------- DUT B ----------------
  logic [3:0]  b_valid = '0, b_last = '0, b_ready, b_grant;
  logic [31:0] b_byte = '0;
  logic        b_dv, b_busy;
  logic [7:0]  b_tx_byte;
  logic [1:0]  b_owner;
  logic        b_active = 1'b0, b_done = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .GAP_CLKS(7)) dut_b (
    .i_Clock(clk), .i_Reset(rst),
    .i_Req_Valid(b_valid), .i_Req_Byte(b_byte), .i_Req_Last(b_last),
    .o_Req_Ready(b_ready), .o_Tx_DV(b_dv), .o_Tx_Byte(b_tx_byte),
    .i_Tx_Active(b_active), .i_Tx_Done(b_done),
    .o_Grant(b_grant), .o_Owner_Idx(b_owner), .o_Busy(b_busy)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name, input int waited);
    checks++;
    errors++;
    $display("FAIL %s: event not seen after %0d cycles", name, waited);
  endtask

  task automatic wait_ready_drop(input int k);
    int n = 0;
    while (!a_ready[k] && n < 3000) begin @(negedge clk); n++; end
    if (!a_ready[k]) fail_now($sformatf("ready_timeout_req%0d", k), n);
    @(posedge clk); #1;
    rv[k] = 1'b0;
  endtask

  task automatic a_send(input int k, input logic [7:0] b, input logic l);
    rb[k] = b; rl[k] = l; rv[k] = 1'b1;
    wait_ready_drop(k);
  endtask

  task automatic push_exp(input logic [1:0] owner, input logic [7:0] b);
    dv_q.push_back({owner, b});
    ser_q.push_back(b);
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((a_busy || a_tx_active || a_tx_done || ser_q.size() != 0 || dv_q.size() != 0) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) fail_now(name, n);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst) begin
      if (a_ready != 4'b0000) rdy_cnt++;
      if (a_dv) begin
        dv_cnt++;
        check("dv_tx_free", {30'd0, a_tx_active, a_tx_done}, 32'd0);
        check("dv_ready_is_grant", {28'd0, a_ready}, {28'd0, a_grant});
        if (dv_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dv_unexpected: got byte 0x%0h owner %0d, expected no DV", a_tx_byte, a_owner);
        end else begin
          e = dv_q.pop_front();
          check("dv_byte", {24'd0, a_tx_byte}, {24'd0, e[7:0]});
          check("dv_owner", {30'd0, a_owner}, {30'd0, e[9:8]});
        end
      end else if (a_ready != 4'b0000) begin
        checks++; errors++;
        $display("FAIL ready_without_dv: got ready 0x%0h, expected 0", a_ready);
      end
    end
  end

  initial begin : ser_mon
    logic [7:0] d;
    logic       s0, s1;
    forever begin
      @(negedge clk);
      if (a_ser == 1'b0) begin
        repeat (2) @(negedge clk);
        s0 = a_ser;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = a_ser;
        end
        repeat (CPB) @(negedge clk);
        s1 = a_ser;
        check("ser_frame", {30'd0, s0, s1}, 32'd1);
        if (ser_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ser_unexpected: got byte 0x%0h, expected none", d);
        end else begin
          check("ser_byte", {24'd0, d}, {24'd0, ser_q.pop_front()});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, d0, r0;
    for (int k = 0; k < 4; k++) begin rv[k] = 1'b0; rb[k] = 8'h00; rl[k] = 1'b0; end

    repeat (2) @(negedge clk);
    check("rst_grant", {28'd0, a_grant}, 32'd0);
    check("rst_owner", {30'd0, a_owner}, 32'd3);
    check("rst_dv", {31'd0, a_dv}, 32'd0);
    check("rst_byte", {24'd0, a_tx_byte}, 32'd0);
    check("rst_ready", {28'd0, a_ready}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_b_owner", {30'd0, b_owner}, 32'd3);
    @(posedge clk); #1 rst = 1'b0;

    // single byte 0x55 from req0
    d0 = dv_cnt;
    push_exp(2'd0, 8'h55);
    @(posedge clk); #1;
    rb[0] = 8'h55; rl[0] = 1'b1; rv[0] = 1'b1;
    @(negedge clk);
    check("t1_dv_not_yet", {31'd0, a_dv}, 32'd0);
    @(negedge clk);
    check("t1_dv_latency", {31'd0, a_dv}, 32'd1);
    wait_ready_drop(0);
    wait_quiet("t1_quiet");
    check("t1_grant_clear", {28'd0, a_grant}, 32'd0);
    check("t1_owner_kept", {30'd0, a_owner}, 32'd0);
    check("t1_dv_count", dv_cnt - d0, 32'd1);

    // round robin among req0..2
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) push_exp(2'(k), 8'hA0 + 8'(k));
    fork
      begin a_send(0, 8'hA0, 1'b1); a_send(0, 8'hA0, 1'b1); end
      begin a_send(1, 8'hA1, 1'b1); a_send(1, 8'hA1, 1'b1); end
      begin a_send(2, 8'hA2, 1'b1); a_send(2, 8'hA2, 1'b1); end
    join
    wait_quiet("t2_quiet");
    check("t2_owner_end", {30'd0, a_owner}, 32'd2);

    // message lock with a HOLD gap while req3 waits
    do_reset();
    push_exp(2'd1, 8'h10); push_exp(2'd1, 8'h11); push_exp(2'd1, 8'h12); push_exp(2'd3, 8'h30);
    fork
      a_send(3, 8'h30, 1'b1);
      begin
        a_send(1, 8'h10, 1'b0);
        a_send(1, 8'h11, 1'b0);
        repeat (65) @(posedge clk);
        @(negedge clk);
        check("t3_hold_grant", {28'd0, a_grant}, 32'h2);
        check("t3_hold_busy", {31'd0, a_busy}, 32'd1);
        check("t3_hold_tx_idle", {31'd0, a_tx_active}, 32'd0);
        check("t3_hold_pending", dv_q.size(), 32'd2);
        a_send(1, 8'h12, 1'b1);
      end
    join
    wait_quiet("t3_quiet");

    // reset in the middle of a byte
    do_reset();
    push_exp(2'd2, 8'h3C); push_exp(2'd2, 8'h3D);
    fork
      begin a_send(2, 8'h3C, 1'b0); a_send(2, 8'h3D, 1'b1); end
      begin
        n = 0;
        while (!a_dv && n < 200) begin @(negedge clk); n++; end
        if (!a_dv) fail_now("t4_first_dv", n);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t4_rst_grant", {28'd0, a_grant}, 32'd0);
        check("t4_rst_owner", {30'd0, a_owner}, 32'd3);
        check("t4_rst_busy", {31'd0, a_busy}, 32'd0);
        check("t4_rst_dv", {31'd0, a_dv}, 32'd0);
        check("t4_rst_byte", {24'd0, a_tx_byte}, 32'd0);
        check("t4_rst_ready", {28'd0, a_ready}, 32'd0);
        check("t4_tx_still_active", {31'd0, a_tx_active}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_dv && n < 200);
        if (!a_dv) fail_now("t4_second_dv", n);
        check("t4_free_at_dv", {30'd0, a_tx_active, a_tx_done}, 32'd0);
        check("t4_prev_byte_done", ser_q.size(), 32'd1);
      end
    join
    wait_quiet("t4_quiet");

    // back-to-back 8-byte message
    do_reset();
    d0 = dv_cnt; r0 = rdy_cnt;
    for (int i = 0; i < 8; i++) push_exp(2'd0, 8'h80 + 8'(i));
    for (int i = 0; i < 8; i++) a_send(0, 8'h80 + 8'(i), (i == 7));
    wait_quiet("t5_quiet");
    check("t5_dv_count", dv_cnt - d0, 32'd8);
    check("t5_ready_count", rdy_cnt - r0, 32'd8);

    // DUT B: two-byte message with GAP_CLKS=7
    b_byte = 32'h0000_00E0; b_last = 4'b0000; b_valid = 4'b0001;
    n = 0;
    while (!b_dv && n < 100) begin @(negedge clk); n++; end
    if (!b_dv) fail_now("g_dv0", n);
    check("g_byte0", {24'd0, b_tx_byte}, 32'hE0);
    @(posedge clk); #1;
    b_byte = 32'h0000_00E1; b_last = 4'b0001; b_active = 1'b1;
    repeat (10) @(posedge clk); #1 b_active = 1'b0; b_done = 1'b1;
    repeat (2) @(posedge clk); #1 b_done = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_dv && n < 100);
    check("g_spacing", n - 1, 32'd8);
    check("g_byte1", {24'd0, b_tx_byte}, 32'hE1);
    check("g_ready1", {28'd0, b_ready}, 32'h1);
    @(posedge clk); #1 b_valid = 4'b0000; b_active = 1'b1;
    repeat (5) @(posedge clk); #1 b_active = 1'b0; b_done = 1'b1;
    repeat (2) @(posedge clk); #1 b_done = 1'b0;
    n = 0;
    while (b_busy && n < 100) begin @(negedge clk); n++; end
    if (b_busy) fail_now("g_idle", n);
    check("g_grant_clear", {28'd0, b_grant}, 32'd0);
    check("g_owner_kept", {30'd0, b_owner}, 32'd0);

    check("end_dv_q_empty", dv_q.size(), 32'd0);
    check("end_ser_q_empty", ser_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
